// File: rtl/param_update_request_gen_pkg.sv
// Shared constants for the rotary-encoder update-request block:
// register map, bit positions and the detent phase limit.
package param_update_pkg;
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ACK    = 2'd1;

    localparam int ST_UP_LSB  = 0;
    localparam int ST_DN_LSB  = 4;
    localparam int ST_OVF_BIT = 8;
    localparam int ST_B_BIT   = 9;
    localparam int ST_A_BIT   = 10;

    localparam int ACK_UP_BIT  = 0;
    localparam int ACK_DN_BIT  = 1;
    localparam int ACK_OVF_BIT = 8;

    localparam logic signed [3:0] PHASE_LIM = 4'sd4;
endpackage

// File: rtl/param_update_request_gen_if.sv
// Avalon-MM slave bus used by software to poll status and acknowledge steps.
interface param_update_request_gen_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (output avs_address, avs_read, avs_write, avs_writedata,
                    input  avs_readdata);
    modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                    output avs_readdata);
endinterface

// File: rtl/param_update_request_gen_debounce.sv
// One encoder contact: 2-FF synchronizer followed by a hold-time debouncer.
module param_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            // any return to the stable level restarts the hold count
            if (r_sync[1] != r_stable) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;
endmodule

// File: rtl/param_update_request_gen.sv
// Rotary encoder to queued up/down step requests, polled and acknowledged
// by software through a small Avalon-MM slave.
module param_update_request_gen
    import param_update_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int PEND_W          = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enc_a,
    input  logic                         enc_b,
    param_update_request_gen_if.slave    avs,
    output logic [1:0]                   update_req
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              w_stable_a, w_stable_b;
    logic [1:0]        w_cur, w_chg, r_prev;
    logic signed [2:0] r_phase;
    logic signed [3:0] w_phase_ext, w_phase_nx;
    logic              w_step_up, w_step_dn;
    logic              w_ack_wr, w_ack_up, w_ack_dn, w_ovf_set;
    logic [PEND_W-1:0] r_up, r_dn;
    logic              r_ovf;
    logic [1:0]        r_upd;
    logic [31:0]       w_status, r_rdata;
    logic              w_unused;

    param_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
        .clk(clk), .reset(reset), .i_raw(enc_a), .o_stable(w_stable_a));
    param_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clk(clk), .reset(reset), .i_raw(enc_b), .o_stable(w_stable_b));

    // CW order 00->01->11->10: a single-bit move is CW when prev[1]^cur[0]
    always_comb begin
        w_cur       = {w_stable_a, w_stable_b};
        w_chg       = w_cur ^ r_prev;
        w_phase_ext = {r_phase[2], r_phase};
        w_phase_nx  = w_phase_ext;
        w_step_up   = 1'b0;
        w_step_dn   = 1'b0;
        if (w_chg == 2'b01 || w_chg == 2'b10) begin
            if (r_prev[1] ^ w_cur[0]) w_phase_nx = w_phase_ext + 4'sd1;
            else                      w_phase_nx = w_phase_ext - 4'sd1;
        end
        if (w_phase_nx == PHASE_LIM) begin
            w_step_up  = 1'b1;
            w_phase_nx = '0;
        end else if (w_phase_nx == -PHASE_LIM) begin
            w_step_dn  = 1'b1;
            w_phase_nx = '0;
        end
    end

    assign w_ack_wr  = avs.avs_write && (avs.avs_address == REG_ACK);
    assign w_ack_up  = w_ack_wr && avs.avs_writedata[ACK_UP_BIT];
    assign w_ack_dn  = w_ack_wr && avs.avs_writedata[ACK_DN_BIT];
    assign w_ovf_set = (w_step_up && !w_ack_up && r_up == PEND_MAX) ||
                       (w_step_dn && !w_ack_dn && r_dn == PEND_MAX);
    assign w_unused  = &{1'b0, avs.avs_writedata};

    always_comb begin
        w_status                       = '0;
        w_status[ST_UP_LSB +: PEND_W]  = r_up;
        w_status[ST_DN_LSB +: PEND_W]  = r_dn;
        w_status[ST_OVF_BIT]           = r_ovf;
        w_status[ST_B_BIT]             = w_stable_b;
        w_status[ST_A_BIT]             = w_stable_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= '0;
            r_phase <= '0;
            r_up    <= '0;
            r_dn    <= '0;
            r_ovf   <= 1'b0;
            r_upd   <= '0;
            r_rdata <= '0;
        end else begin
            r_prev  <= w_cur;
            r_phase <= w_phase_nx[2:0];

            if (w_step_up && !w_ack_up && r_up != PEND_MAX) r_up <= r_up + 1'b1;
            else if (w_ack_up && !w_step_up && r_up != '0)  r_up <= r_up - 1'b1;

            if (w_step_dn && !w_ack_dn && r_dn != PEND_MAX) r_dn <= r_dn + 1'b1;
            else if (w_ack_dn && !w_step_dn && r_dn != '0)  r_dn <= r_dn - 1'b1;

            // a new overflow outranks a clear in the same cycle
            if (w_ovf_set)                                       r_ovf <= 1'b1;
            else if (w_ack_wr && avs.avs_writedata[ACK_OVF_BIT]) r_ovf <= 1'b0;

            r_upd <= {r_dn != '0, r_up != '0};

            if (avs.avs_read)
                r_rdata <= (avs.avs_address == REG_STATUS) ? w_status : '0;
        end
    end

    assign update_req       = r_upd;
    assign avs.avs_readdata = r_rdata;
endmodule

// File: tb/tb_param_update_request_gen.sv
// Directed bench: a per-cycle behavioural model of the encoder block plus
// literal expectations at the end of each scenario.
module tb_param_update_request_gen;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0, enc_b = 1'b0;
    logic [1:0] update_req;
    param_update_request_gen_if bus();

    int tests = 0, fails = 0;

    param_update_request_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(16), .PEND_W(4)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .avs(bus), .update_req(update_req));

    always #5 clk = ~clk;

    initial begin
        bus.avs_address   = 2'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'd0;
    end

    // ---------------- behavioural model ----------------
    logic [5:0]  m_ha = '0, m_hb = '0;   // bit k = raw level k+1 cycles ago
    logic        m_sa = 1'b0, m_sb = 1'b0;
    logic [1:0]  m_prev = '0;
    int          m_phase = 0, m_up = 0, m_dn = 0;
    logic        m_ovf = 1'b0;
    logic [1:0]  m_upd = '0;
    logic [31:0] m_rd = '0;

    function automatic int gpos(logic [1:0] ab);
        case (ab)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    // the contact flips once its synchronized level has disagreed for DB cycles
    function automatic logic settled(logic [5:0] h, logic s);
        for (int k = 1; k <= DB; k++) if (h[k] == s) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_ha = '0; m_hb = '0; m_sa = 0; m_sb = 0; m_prev = '0;
                m_phase = 0; m_up = 0; m_dn = 0; m_ovf = 0; m_upd = '0; m_rd = '0;
            end else begin
                logic su, sd, aw, au, ad;
                int d;
                if (bus.avs_read)
                    m_rd = (bus.avs_address == 2'd0) ?
                           (32'(m_up) | (32'(m_dn) << 4) | (32'(m_ovf) << 8) |
                            (32'(m_sb) << 9) | (32'(m_sa) << 10)) : 32'd0;
                m_upd = {m_dn != 0, m_up != 0};
                su = 0; sd = 0;
                d = (gpos({m_sa, m_sb}) - gpos(m_prev) + 4) % 4;
                if (d == 1) m_phase++;
                else if (d == 3) m_phase--;
                if (m_phase == 4)  begin su = 1; m_phase = 0; end
                if (m_phase == -4) begin sd = 1; m_phase = 0; end
                aw = bus.avs_write && bus.avs_address == 2'd1;
                au = aw && bus.avs_writedata[0];
                ad = aw && bus.avs_writedata[1];
                if (su && !au) begin if (m_up == 15) m_ovf = 1; else m_up++; end
                else if (au && !su && m_up > 0) m_up--;
                if (sd && !ad) begin if (m_dn == 15) m_ovf = 1; else m_dn++; end
                else if (ad && !sd && m_dn > 0) m_dn--;
                if (aw && bus.avs_writedata[8] && !((su && !au && m_up == 15) ||
                    (sd && !ad && m_dn == 15)))
                    m_ovf = 0;
                m_prev = {m_sa, m_sb};
                if (settled(m_ha, m_sa)) m_sa = ~m_sa;
                if (settled(m_hb, m_sb)) m_sb = ~m_sb;
                m_ha = {m_ha[4:0], enc_a};
                m_hb = {m_hb[4:0], enc_b};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle after reset: compare registered outputs with the model
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            chk("update_req", {30'd0, update_req}, {30'd0, m_upd});
            chk("readdata", bus.avs_readdata, m_rd);
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        enc_a = a; enc_b = b; cyc(hold);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] d);
        bus.avs_address = addr; bus.avs_read = 1'b1;
        cyc(1);
        bus.avs_read = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.avs_address = addr; bus.avs_writedata = data; bus.avs_write = 1'b1;
        cyc(1);
        bus.avs_write = 1'b0;
    endtask

    task automatic cw_detent();
        set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(1, 0, 10); set_ab(0, 0, 10);
    endtask

    task automatic ccw_detent();
        set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 1, 10); set_ab(0, 0, 10);
    endtask

    initial begin
        logic [31:0] d;
        @(posedge clk); #1;
        cyc(2);
        reset = 1'b0;
        rd(0, d); chk("reset_status", d, 32'h0);
        chk("reset_upd", {30'd0, update_req}, 32'h0);

        // reset in the middle of a detent
        set_ab(0, 1, 10); set_ab(1, 1, 10);
        enc_a = 0; enc_b = 0; reset = 1'b1; cyc(2); reset = 1'b0; cyc(10);
        rd(0, d); chk("midrot_reset_status", d, 32'h0);
        chk("midrot_reset_upd", {30'd0, update_req}, 32'h0);
        set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(1, 0, 10);
        rd(0, d); chk("partial_no_step", d, 32'h400);
        set_ab(0, 0, 10);
        rd(0, d); chk("cw_detent_status", d, 32'h001);
        chk("cw_detent_upd", {30'd0, update_req}, 32'h1);
        wr(1, 32'h1); cyc(2);
        chk("ack_up_upd", {30'd0, update_req}, 32'h0);
        rd(0, d); chk("ack_up_status", d, 32'h0);

        // bounce on contact A shorter than the hold time
        for (int i = 0; i < 10; i++) begin
            enc_a = ~enc_a;
            repeat (2) begin rd(0, d); chk("bounce_stable_a", d & 32'h400, 32'h0); end
        end
        set_ab(1, 0, 10);
        rd(0, d); chk("bounce_settled", d, 32'h400);
        set_ab(0, 0, 10);
        rd(0, d); chk("bounce_no_step", d, 32'h0);
        chk("bounce_upd", {30'd0, update_req}, 32'h0);

        // saturate the down counter
        for (int i = 0; i < 16; i++) ccw_detent();
        rd(0, d); chk("ccw_saturate", d, 32'h1F0);
        chk("ccw_upd", {30'd0, update_req}, 32'h2);
        wr(1, 32'h100);
        rd(0, d); chk("ovf_clear", d, 32'h0F0);
        for (int i = 0; i < 15; i++) wr(1, 32'h2);
        cyc(2);
        rd(0, d); chk("dn_drained", d, 32'h0);
        chk("dn_drained_upd", {30'd0, update_req}, 32'h0);

        // ack landing on the same cycle as a step
        cw_detent(); cw_detent();
        rd(0, d); chk("up_two", d, 32'h002);
        set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(1, 0, 10);
        enc_a = 0; enc_b = 0; cyc(6);
        bus.avs_address = 2'd1; bus.avs_writedata = 32'h1; bus.avs_write = 1'b1;
        cyc(1); bus.avs_write = 1'b0;
        cyc(10);
        rd(0, d); chk("step_with_ack", d, 32'h002);
        repeat (3) wr(1, 32'h1);
        cyc(2);
        rd(0, d); chk("ack_at_zero", d, 32'h0);
        chk("ack_at_zero_upd", {30'd0, update_req}, 32'h0);

        // both contacts changing together is ignored
        set_ab(1, 1, 10);
        rd(0, d); chk("illegal_00_11", d, 32'h600);
        set_ab(0, 0, 10);
        rd(0, d); chk("illegal_11_00", d, 32'h0);
        cw_detent();
        rd(0, d); chk("after_illegal_one_step", d, 32'h001);
        rd(2, d); chk("addr2_zero", d, 32'h0);
        rd(3, d); chk("addr3_zero", d, 32'h0);
        rd(1, d); chk("addr1_zero", d, 32'h0);
        wr(2, 32'h3); wr(0, 32'h1);
        rd(0, d); chk("ignored_writes", d, 32'h001);

        cyc(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
